// File: rtl/ad_demod_pkg.sv
// Shared constants, FSM encoding and ADC sample conversion for the quadrature demodulator.
package ad_demod_pkg;

   localparam int ADC_W  = 14;
   localparam int REF_W  = 14;
   localparam int PROD_W = 28;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_e;

   // AD9240 offset binary to two's complement: flip the MSB.
   function automatic logic signed [ADC_W-1:0] ob_to_signed(input logic [ADC_W-1:0] raw);
      return {~raw[ADC_W-1], raw[ADC_W-2:0]};
   endfunction

endpackage

// File: rtl/ad_demod_mac.sv
// One demodulation channel: registered signed product (S2) feeding a sign-extended accumulator (S3).
module demod_mac
   import ad_demod_pkg::*;
#(
   parameter int ACC_W = 40
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    clr_i,
   input  logic                    valid_i,
   input  logic signed [ADC_W-1:0] samp_i,
   input  logic signed [REF_W-1:0] ref_i,
   output logic signed [ACC_W-1:0] acc_o
);

   logic signed [PROD_W-1:0] prod_q, prod_d;
   logic                     prod_vld_q, prod_vld_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;

   always_comb begin
      prod_d     = samp_i * ref_i;
      prod_vld_d = valid_i & ~clr_i;
      acc_d      = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (prod_vld_q) begin
         acc_d = acc_q + {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prod_q     <= '0;
         prod_vld_q <= 1'b0;
         acc_q      <= '0;
      end else begin
         prod_q     <= prod_d;
         prod_vld_q <= prod_vld_d;
         acc_q      <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/ad_demod.sv
// Quadrature demodulator: accumulates sample*sin and sample*cos over SAMP_NUM accepted samples.
module ad_demod
   import ad_demod_pkg::*;
#(
   parameter int SAMP_NUM = 500,
   parameter int ACC_W    = 40
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    Enable,
   input  logic                    SampValid,
   input  logic [ADC_W-1:0]        DataIn,
   input  logic                    OTR,
   input  logic signed [REF_W-1:0] SinRef,
   input  logic signed [REF_W-1:0] CosRef,
   output logic                    Done,
   output logic signed [ACC_W-1:0] IOut,
   output logic signed [ACC_W-1:0] QOut,
   output logic                    Ovf,
   output logic                    Busy
);

   localparam int              CNT_W = $clog2(SAMP_NUM + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMP_NUM - 1);

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    flush_q, flush_d;
   logic                    ovf_q, ovf_d;
   logic                    accept;
   logic                    mac_clr;

   logic                    s1_vld_q;
   logic signed [ADC_W-1:0] s1_samp_q;
   logic signed [REF_W-1:0] s1_ref_q [2];
   logic signed [ACC_W-1:0] acc      [2];

   logic                    done_q, done_d;
   logic signed [ACC_W-1:0] iout_q, iout_d;
   logic signed [ACC_W-1:0] qout_q, qout_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      flush_d = flush_q;
      ovf_d   = ovf_q;
      accept  = 1'b0;
      if (!Enable) begin
         state_d = IDLE;
         cnt_d   = '0;
         flush_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = RUN;
               cnt_d   = '0;
               flush_d = 1'b0;
               ovf_d   = 1'b0;
            end
            RUN: begin
               if (SampValid) begin
                  accept = 1'b1;
                  cnt_d  = cnt_q + 1'b1;
                  ovf_d  = ovf_q | OTR;
                  if (cnt_q == LAST) begin
                     state_d = FLUSH;
                  end
               end
            end
            FLUSH: begin
               flush_d = ~flush_q;
               if (flush_q) begin
                  state_d = DONE;
               end
            end
            default: ;
         endcase
      end
   end

   // Results are captured one edge after entering DONE, once S3 has absorbed the last product.
   always_comb begin
      done_d = done_q;
      iout_d = iout_q;
      qout_d = qout_q;
      if (!Enable) begin
         done_d = 1'b0;
      end else if (state_q == DONE && !done_q) begin
         done_d = 1'b1;
         iout_d = acc[0];
         qout_d = acc[1];
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         flush_q <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
         iout_q  <= '0;
         qout_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         flush_q <= flush_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
         iout_q  <= iout_d;
         qout_q  <= qout_d;
      end
   end

   // S1: converted sample and both references.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         s1_vld_q    <= 1'b0;
         s1_samp_q   <= '0;
         s1_ref_q[0] <= '0;
         s1_ref_q[1] <= '0;
      end else begin
         s1_vld_q <= accept;
         if (accept) begin
            s1_samp_q   <= ob_to_signed(DataIn);
            s1_ref_q[0] <= SinRef;
            s1_ref_q[1] <= CosRef;
         end
      end
   end

   assign mac_clr = ~Enable | (state_q == IDLE);

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_chan
         demod_mac #(
            .ACC_W(ACC_W)
         ) u_mac (
            .clk_i  (CLK),
            .rst_ni (RST),
            .clr_i  (mac_clr),
            .valid_i(s1_vld_q),
            .samp_i (s1_samp_q),
            .ref_i  (s1_ref_q[gi]),
            .acc_o  (acc[gi])
         );
      end
   endgenerate

   assign Done = done_q;
   assign IOut = iout_q;
   assign QOut = qout_q;
   assign Ovf  = ovf_q;
   assign Busy = (state_q == RUN) | (state_q == FLUSH);

endmodule

// File: tb/tb_ad_demod.sv
// Scoreboard bench for ad_demod: random and directed runs against an arithmetic sum model.
module tb_ad_demod;

   typedef struct {
      longint i;
      longint q;
      bit     ovf;
      int     cyc;
   } exp_t;

   logic CLK = 1'b0;
   logic RST;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   // DUT A: SAMP_NUM = 4
   logic               en_a, sv_a, otr_a;
   logic [13:0]        din_a;
   logic signed [13:0] sin_a, cos_a;
   logic               done_a, ovf_a, busy_a;
   logic signed [39:0] i_a, q_a;
   // DUT W: SAMP_NUM = 2047
   logic               en_w, sv_w, otr_w;
   logic [13:0]        din_w;
   logic signed [13:0] sin_w, cos_w;
   logic               done_w, ovf_w, busy_w;
   logic signed [39:0] i_w, q_w;

   exp_t   exp_a[$];
   exp_t   exp_w[$];
   longint prev_i = 0, prev_q = 0;
   logic   done_a_prev = 1'b0, done_w_prev = 1'b0;

   ad_demod #(.SAMP_NUM(4), .ACC_W(40)) dut_a (
      .CLK(CLK), .RST(RST), .Enable(en_a), .SampValid(sv_a), .DataIn(din_a), .OTR(otr_a),
      .SinRef(sin_a), .CosRef(cos_a), .Done(done_a), .IOut(i_a), .QOut(q_a),
      .Ovf(ovf_a), .Busy(busy_a)
   );

   ad_demod #(.SAMP_NUM(2047), .ACC_W(40)) dut_w (
      .CLK(CLK), .RST(RST), .Enable(en_w), .SampValid(sv_w), .DataIn(din_w), .OTR(otr_w),
      .SinRef(sin_w), .CosRef(cos_w), .Done(done_w), .IOut(i_w), .QOut(q_w),
      .Ovf(ovf_w), .Busy(busy_w)
   );

   always #50 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [13:0] r14();
      return 14'($urandom);
   endfunction

   // Monitors: compare whenever Done rises.
   always @(negedge CLK) begin
      exp_t e;
      if (done_a && !done_a_prev) begin
         if (exp_a.size() == 0) begin
            chk("a_unexpected_done", 1, 0);
         end else begin
            e = exp_a.pop_front();
            chk("a_iout", i_a, e.i);
            chk("a_qout", q_a, e.q);
            chk("a_ovf", longint'(ovf_a), longint'(e.ovf));
            chk("a_latency", cyc, e.cyc);
            $display("run A: I=%0d Q=%0d ovf=%0d at cycle %0d", i_a, q_a, ovf_a, cyc);
         end
      end
      done_a_prev <= done_a;
   end

   always @(negedge CLK) begin
      exp_t e;
      if (done_w && !done_w_prev) begin
         if (exp_w.size() == 0) begin
            chk("w_unexpected_done", 1, 0);
         end else begin
            e = exp_w.pop_front();
            chk("w_iout", i_w, e.i);
            chk("w_qout", q_w, e.q);
            chk("w_ovf", longint'(ovf_w), longint'(e.ovf));
            chk("w_latency", cyc, e.cyc);
            $display("run W: I=%0d Q=%0d ovf=%0d at cycle %0d", i_w, q_w, ovf_w, cyc);
         end
      end
      done_w_prev <= done_w;
   end

   // mode: 0 random, 1 full-scale, 2 midscale, 3 gaps/OTR idle only, 4 gaps/OTR on 3rd accept,
   // 5 sample offered on the Enable-rise cycle
   task automatic run_a(input int mode, input int abort_after, input bit rst_flush);
      longint             ei = 0, eq = 0;
      bit                 eo = 1'b0;
      int                 acc_n = 0, k = 0, last_cyc = 0;
      int                 pat[7] = '{1, 0, 0, 1, 1, 0, 1};
      logic [13:0]        d;
      logic signed [13:0] s, c;
      logic               v, o;

      en_a  = 1'b1;
      sv_a  = (mode == 5);
      otr_a = (mode == 5);
      din_a = 14'h3FFF;
      sin_a = 14'sd1000;
      cos_a = 14'sd1000;
      @(negedge CLK);
      chk("a_busy_run", longint'(busy_a), 1);
      while (acc_n < 4) begin
         case (mode)
            1: begin d = 14'h3FFF; s = 14'sd4096; c = -14'sd4096; v = 1'b1; o = 1'b0; end
            2: begin d = 14'h2000; s = r14(); c = r14(); v = 1'b1; o = 1'b0; end
            3, 4: begin
               v = pat[k % 7] != 0;
               d = r14(); s = r14(); c = r14();
               o = v ? (mode == 4 && acc_n == 2) : 1'b1;
            end
            default: begin
               v = $urandom_range(0, 3) != 0;
               d = r14(); s = r14(); c = r14();
               o = $urandom_range(0, 9) == 0;
            end
         endcase
         sv_a = v; din_a = d; sin_a = s; cos_a = c; otr_a = o;
         if (v) begin
            ei += (longint'(d) - 8192) * longint'(s);
            eq += (longint'(d) - 8192) * longint'(c);
            eo |= o;
            acc_n++;
            if (acc_n == 4) last_cyc = cyc + 1;
         end
         k++;
         @(negedge CLK);
         if (abort_after != 0 && acc_n == abort_after) begin
            en_a = 1'b0; sv_a = 1'b0;
            @(negedge CLK);
            chk("abort_done", longint'(done_a), 0);
            chk("abort_busy", longint'(busy_a), 0);
            chk("abort_iout", i_a, prev_i);
            chk("abort_qout", q_a, prev_q);
            $display("run A: aborted after %0d samples", acc_n);
            return;
         end
      end
      if (rst_flush) begin
         sv_a = 1'b1; din_a = r14();
         #10 RST = 1'b0;
         #1;
         chk("rst_done", longint'(done_a), 0);
         chk("rst_iout", i_a, 0);
         chk("rst_qout", q_a, 0);
         chk("rst_ovf", longint'(ovf_a), 0);
         chk("rst_busy", longint'(busy_a), 0);
         prev_i = 0; prev_q = 0;
         @(negedge CLK);
         RST = 1'b1;
         $display("run A: async reset during flush");
         return;
      end
      exp_a.push_back('{i: ei, q: eq, ovf: eo, cyc: last_cyc + 3});
      for (int t = 0; t < 8 && !done_a; t++) begin
         sv_a = $urandom_range(0, 1) != 0; din_a = r14(); otr_a = 1'b1;
         @(negedge CLK);
      end
      if (!done_a) chk("a_done_timeout", 0, 1);
      for (int t = 0; t < 2; t++) begin
         sv_a = 1'b1; din_a = r14(); otr_a = 1'b1;
         @(negedge CLK);
      end
      chk("a_hold_iout", i_a, ei);
      chk("a_hold_done", longint'(done_a), 1);
      prev_i = ei; prev_q = eq;
      en_a = 1'b0; sv_a = 1'b0; otr_a = 1'b0;
      @(negedge CLK);
      chk("a_disable_done", longint'(done_a), 0);
      chk("a_disable_iout", i_a, ei);
   endtask

   task automatic run_w();
      longint ei = 0, eq = 0;
      int     last_cyc = 0;
      en_w = 1'b1; sv_w = 1'b0;
      @(negedge CLK);
      for (int n = 0; n < 2047; n++) begin
         sv_w = 1'b1; din_w = 14'h0000; sin_w = 14'h2000; cos_w = r14(); otr_w = 1'b0;
         ei += (longint'(din_w) - 8192) * longint'(sin_w);
         eq += (longint'(din_w) - 8192) * longint'(cos_w);
         if (n == 2046) last_cyc = cyc + 1;
         @(negedge CLK);
      end
      exp_w.push_back('{i: ei, q: eq, ovf: 1'b0, cyc: last_cyc + 3});
      sv_w = 1'b0;
      for (int t = 0; t < 8 && !done_w; t++) @(negedge CLK);
      if (!done_w) chk("w_done_timeout", 0, 1);
      en_w = 1'b0;
      @(negedge CLK);
   endtask

   initial begin
      RST = 1'b0;
      en_a = 0; sv_a = 0; otr_a = 0; din_a = '0; sin_a = '0; cos_a = '0;
      en_w = 0; sv_w = 0; otr_w = 0; din_w = '0; sin_w = '0; cos_w = '0;
      @(negedge CLK); @(negedge CLK);
      chk("reset_done", longint'(done_a), 0);
      chk("reset_iout", i_a, 0);
      chk("reset_qout", q_a, 0);
      chk("reset_ovf", longint'(ovf_a), 0);
      chk("reset_busy", longint'(busy_a), 0);
      chk("reset_w_iout", i_w, 0);
      RST = 1'b1;
      @(negedge CLK);

      run_a(1, 0, 1'b0);
      run_a(2, 0, 1'b0);
      run_a(3, 0, 1'b0);
      run_a(4, 0, 1'b0);
      run_a(0, 2, 1'b0);
      run_a(0, 0, 1'b0);
      run_a(5, 0, 1'b0);
      run_a(0, 0, 1'b1);
      run_a(0, 0, 1'b0);
      for (int r = 0; r < 12; r++) run_a($urandom_range(0, 1) != 0 ? 0 : 3, 0, 1'b0);
      run_w();

      repeat (3) @(negedge CLK);
      chk("queue_a_empty", exp_a.size(), 0);
      chk("queue_w_empty", exp_w.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
